// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;
  localparam int NREGS  = 4;
  localparam int DW     = 8;
  localparam int QDEPTH = 2;

  typedef logic [1:0]    reg_idx_t;
  typedef logic [DW-1:0] data_t;

  typedef struct packed {
    reg_idx_t rd;
    data_t    val;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_mask(input reg_idx_t r);
    reg_mask    = '0;
    reg_mask[r] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// Two-entry in-order holding queue for ALU results that lost the write port.
module wb_queue
  import regfile_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [QDEPTH-1:0]        ent_vld,
  output reg_idx_t [QDEPTH-1:0]    ent_rd
);

  wb_entry_t [QDEPTH-1:0] ent_q, ent_d;
  logic [QDEPTH-1:0]      vld_q, vld_d;

  // Entries stay packed toward slot 0, so slot 0 is always the head.
  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    if (pop) begin
      ent_d[0] = ent_q[1];
      vld_d[0] = vld_q[1];
      vld_d[1] = 1'b0;
    end
    if (push) begin
      if (!vld_d[0]) begin
        ent_d[0] = din;
        vld_d[0] = 1'b1;
      end else begin
        ent_d[1] = din;
        vld_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q <= '0;
      vld_q <= '0;
    end else begin
      ent_q <= ent_d;
      vld_q <= vld_d;
    end
  end

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) ent_rd[i] = ent_q[i].rd;
  end

  assign head    = ent_q[0];
  assign full    = vld_q[1];
  assign empty   = !vld_q[0];
  assign ent_vld = vld_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between load returns and ALU
// results, and publishes a per-register busy scoreboard for hazard stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  reg_idx_t         alu_reg,
  input  data_t            alu_data,
  output logic             alu_ready,
  input  logic             ld_issue,
  input  reg_idx_t         ld_issue_reg,
  output logic             ld_issue_ready,
  input  logic             ld_valid,
  input  data_t            ld_data,
  output logic             rf_write_en,
  output reg_idx_t         rf_write_reg,
  output data_t            rf_write_value,
  output logic [NREGS-1:0] busy
);

  logic     ld_pend_q, ld_pend_d;
  reg_idx_t ld_reg_q, ld_reg_d;
  logic     out_en_q, out_en_d;
  reg_idx_t out_reg_q, out_reg_d;
  data_t    out_val_q, out_val_d;

  logic                  q_push, q_pop, q_full, q_empty;
  wb_entry_t             q_head;
  logic [QDEPTH-1:0]     q_vld;
  reg_idx_t [QDEPTH-1:0] q_rd;

  logic ld_ret, alu_acc;

  wb_queue u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (q_push),
    .pop     (q_pop),
    .din     ('{rd: alu_reg, val: alu_data}),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .ent_vld (q_vld),
    .ent_rd  (q_rd)
  );

  // A WAW onto the outstanding load must wait, or the late load would clobber it.
  assign alu_ready      = !q_full && !(ld_pend_q && (alu_reg == ld_reg_q));
  assign alu_acc        = alu_valid && alu_ready;
  assign ld_ret         = ld_valid && ld_pend_q;
  assign ld_issue_ready = !ld_pend_q || ld_ret;

  always_comb begin
    out_en_d  = 1'b0;
    out_reg_d = out_reg_q;
    out_val_d = out_val_q;
    q_pop     = 1'b0;
    q_push    = 1'b0;
    if (ld_ret) begin
      out_en_d  = 1'b1;
      out_reg_d = ld_reg_q;
      out_val_d = ld_data;
      q_push    = alu_acc;
    end else if (!q_empty) begin
      out_en_d  = 1'b1;
      out_reg_d = q_head.rd;
      out_val_d = q_head.val;
      q_pop     = 1'b1;
      q_push    = alu_acc;
    end else if (alu_acc) begin
      out_en_d  = 1'b1;
      out_reg_d = alu_reg;
      out_val_d = alu_data;
    end
  end

  always_comb begin
    ld_pend_d = ld_pend_q && !ld_ret;
    ld_reg_d  = ld_reg_q;
    if (ld_issue && ld_issue_ready) begin
      ld_pend_d = 1'b1;
      ld_reg_d  = ld_issue_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_pend_q <= 1'b0;
      ld_reg_q  <= '0;
      out_en_q  <= 1'b0;
      out_reg_q <= '0;
      out_val_q <= '0;
    end else begin
      ld_pend_q <= ld_pend_d;
      ld_reg_q  <= ld_reg_d;
      out_en_q  <= out_en_d;
      out_reg_q <= out_reg_d;
      out_val_q <= out_val_d;
    end
  end

  always_comb begin
    busy = '0;
    if (ld_pend_q) busy = busy | reg_mask(ld_reg_q);
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i]) busy = busy | reg_mask(q_rd[i]);
    end
    if (out_en_q) busy = busy | reg_mask(out_reg_q);
  end

  assign rf_write_en    = out_en_q;
  assign rf_write_reg   = out_reg_q;
  assign rf_write_value = out_val_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write_en / write_reg / write_value) between two writeback sources: the ALU (single-cycle results) and the load unit (variable-latency returns).
- Load returns always win the port. Conflicting ALU results are held in a 2-entry in-order queue.
- Keeps a per-register busy scoreboard so decode can stall on read-after-write hazards.
- Sits between execute/memory and the 4x8-bit register file.

Parameters:
- NREGS, 4, number of architectural registers; fixed, sets the 2-bit index width.
- DW, 8, data width.
- QDEPTH, 2, ALU holding-queue depth; fixed at 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_reg  in  2  ALU destination register
- alu_data  in  8  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
- ld_issue  in  1  load issued; reserves destination register
- ld_issue_reg  in  2  load destination register
- ld_issue_ready  out  1  no load outstanding; ld_issue honoured only when high
- ld_valid  in  1  load data returning this cycle
- ld_data  in  8  load data
- rf_write_en  out  1  register-file write enable (registered)
- rf_write_reg  out  2  register-file write index (registered)
- rf_write_value  out  8  register-file write data (registered)
- busy  out  4  bit i high = write to register i pending (load outstanding, or queued/in output stage)

Behaviour:
- Reset values: rf_write_en=0, rf_write_reg=0, rf_write_value=0, busy=0, queue empty, no load pending, alu_ready=1, ld_issue_ready=1.
- Output stage: one register feeds rf_write_*. Each cycle selects at most one source, in priority order:
  1. ld_valid with a load pending: output gets {ld_issue_reg latched, ld_data}.
  2. Queue non-empty: pop head into output.
  3. Accepted ALU result with queue empty: bypass into output.
  4. Nothing selected: rf_write_en=0 next cycle.
- Latency:
  - Uncontended ALU: accepted at edge N, rf_write_en high for cycle N+1.
  - Load: ld_valid at edge M, write in cycle M+1.
- Queue rules:
  - An accepted ALU result is enqueued when it is not bypassed: a load was selected that cycle, or the queue is non-empty (preserves order).
  - Pop and push in the same cycle are legal.
  - alu_ready = !queue_full && !(load_pending && alu_reg==pending_reg). Stalling a write-after-write onto an outstanding load keeps the older load from overwriting it.
  - Combinational alu_ready depends on alu_reg; the ALU must not drop valid while not ready.
- Load tracking (one outstanding load max):
  - ld_issue & ld_issue_ready latches the register and sets load_pending.
  - load_pending clears on the edge that captures ld_valid.
  - ld_valid with no load pending is ignored; no write occurs.
  - ld_issue in the same cycle as ld_valid is honoured. ld_issue_ready is high that cycle because the return frees the slot; the new reservation takes effect that edge.
- busy: OR of the pending load register, valid queue-entry registers, and the output-stage register when rf_write_en is high. The bit drops the cycle after the write is performed.
- Reset mid-operation discards the queue, the pending load, and the output write. No partial write is issued.
- Queue full with ALU contending and a load returning: alu_ready=0. The load is written and the head stays. Order is preserved; nothing is lost.

Decomposition:
- Package regfile_pkg holds:
  - reg_idx_t (logic [1:0]) and data_t (logic [7:0])
  - NREGS, DW constants
  - wb_entry_t struct {reg_idx_t rd; data_t val;}
- Sub-module wb_queue: 2-entry synchronous FIFO of wb_entry_t with push/pop/full/empty and per-entry valid/rd exposed for busy.
- The arbiter, load tracker, and output stage stay in the top module.

Test Plan:
- Reset mid-traffic: queue holding 2 entries, load pending, assert reset -> next cycle rf_write_en=0, busy=0, alu_ready=1, ld_issue_ready=1.
- Lone ALU write: alu_valid, alu_reg=2, alu_data=0x5A at cycle 0 -> cycle 1 rf_write_en=1, rf_write_reg=2, rf_write_value=0x5A; busy[2]=1 in cycle 1, 0 in cycle 2.
- Load-priority conflict:
  - Stimulus: ld_issue reg 1 at cycle 0. At cycle 3, ld_valid with 0x33 together with ALU reg 3 = 0x11.
  - Response: cycle 4 writes r1=0x33, cycle 5 writes r3=0x11; busy[1] high cycles 1-4.
- Queue fill:
  - Stimulus: load returning while ALU pushes regs 0, 2, 3 back-to-back, with ld_valid asserted on the first ALU cycle.
  - Response: alu_ready drops when queue full. Writes appear in order load, r0, r2, r3, one per cycle, with no duplicates or drops.
- Write-after-write block: load pending to r2 and alu_valid with alu_reg=2 -> alu_ready=0 until the load returns. Final r2 equals the ALU value, written after the load value.
- Spurious return and issue: ld_valid with no pending load -> no write. A second ld_issue while pending -> ld_issue_ready=0 and the original register is kept.
